// File: rtl/sysbus_responder_if.sv
`default_nettype none
// -------------------------------------------------------------------
// sysbus_responder_if : Sysbus request/response bundle      (rev 1.0)
// -------------------------------------------------------------------
interface sysbus_responder_if #(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 13
);
   logic                  reqcyc;
   logic [DATA_WIDTH-1:0] req;
   logic [TAG_WIDTH-1:0]  reqtag;
   logic                  reqack;
   logic                  respcyc;
   logic [DATA_WIDTH-1:0] resp;
   logic [TAG_WIDTH-1:0]  resptag;
   logic                  respack;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );
endinterface
`default_nettype wire

// File: rtl/sysbus_responder.sv
`default_nettype none
// -------------------------------------------------------------------
// sysbus_responder : line-burst memory responder for Sysbus (rev 1.0)
// -------------------------------------------------------------------
module sysbus_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 4096,
   parameter int LATENCY        = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   sysbus_responder_if.slave            bus,
   input  logic                         init_we,
   input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
   input  logic [63:0]                  init_data
);
   localparam int AW     = $clog2(MEM_WORDS);
   localparam int LW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int RW_BIT = 12;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACK   = 3'd1,
      WDATA = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t                    state;
   logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic [BUS_TAG_WIDTH-1:0]  tag;
   logic [AW-4:0]             line;
   logic [2:0]                beat;
   logic [LW-1:0]             lat;
   logic [AW-1:0]             word_idx;
   logic                      bus_wr;
   logic                      enter_resp;

   assign word_idx   = {line, beat};
   assign bus_wr     = (state == WDATA) && bus.reqcyc && !reset;
   assign enter_resp = ((state == ACK) && tag[RW_BIT] && (LATENCY == 1)) ||
                       ((state == WAIT) && (lat == LW'(1)));

   // Bus beat is applied last so it wins over a same-word backdoor write.
   always_ff @(posedge clk) begin
      if (init_we) mem[init_addr] <= init_data;
      if (bus_wr)  mem[word_idx]  <= bus.req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bus.reqack  <= 1'b0;
         bus.respcyc <= 1'b0;
         bus.resp    <= '0;
         bus.resptag <= '0;
         tag         <= '0;
         line        <= '0;
         beat        <= '0;
         lat         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.reqcyc) begin
                  tag        <= bus.reqtag;
                  line       <= bus.req[AW+2:6];
                  bus.reqack <= 1'b1;
                  state      <= ACK;
               end
            end
            ACK: begin
               bus.reqack <= 1'b0;
               beat       <= '0;
               lat        <= LW'(LATENCY - 1);
               if (!tag[RW_BIT])      state <= WDATA;
               else if (LATENCY == 1) state <= RESP;
               else                   state <= WAIT;
            end
            WDATA: begin
               if (bus.reqcyc) begin
                  beat <= beat + 3'd1;
                  if (beat == 3'd7) state <= IDLE;
               end
            end
            WAIT: begin
               lat <= lat - LW'(1);
               if (lat == LW'(1)) state <= RESP;
            end
            RESP: begin
               if (bus.respack) begin
                  if (beat == 3'd7) begin
                     state       <= IDLE;
                     bus.respcyc <= 1'b0;
                     bus.resp    <= '0;
                  end else begin
                     beat     <= beat + 3'd1;
                     bus.resp <= mem[{line, beat + 3'd1}];
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // First beat is fetched on the edge that enters RESP so it is visible immediately.
         if (enter_resp) begin
            bus.respcyc <= 1'b1;
            bus.resp    <= mem[{line, 3'd0}];
            bus.resptag <= tag;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sysbus_responder.sv
`default_nettype none
// tb_sysbus_responder : directed checks of read/write bursts, backpressure, aliasing and reset.
module tb_sysbus_responder;
   localparam int DW        = 64;
   localparam int TW        = 13;
   localparam int MEM_WORDS = 4096;
   localparam int LATENCY   = 4;
   localparam int AW        = $clog2(MEM_WORDS);

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          init_we   = 1'b0;
   logic [AW-1:0] init_addr = '0;
   logic [63:0]   init_data = '0;

   int checks = 0;
   int passes = 0;

   logic [63:0] cap_d [8];
   logic [12:0] cap_t [8];
   int          cap_n;
   int          cap_acks;
   int          cap_first;

   sysbus_responder_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

   sysbus_responder #(
      .BUS_DATA_WIDTH(DW),
      .BUS_TAG_WIDTH (TW),
      .MEM_WORDS     (MEM_WORDS),
      .LATENCY       (LATENCY)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .init_we  (init_we),
      .init_addr(init_addr),
      .init_data(init_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [63:0] d);
      init_we   = 1'b1;
      init_addr = a;
      init_data = d;
      tick();
      init_we   = 1'b0;
   endtask

   // Issues a header with respack tied high and captures the burst (bounded).
   task automatic collect_burst(input logic [63:0] addr, input logic [12:0] tag, input bit hold);
      int cyc;
      cap_n = 0; cap_acks = 0; cap_first = -1;
      for (int i = 0; i < 8; i++) begin cap_d[i] = '0; cap_t[i] = '0; end
      bus.reqcyc  = 1'b1;
      bus.req     = addr;
      bus.reqtag  = tag;
      bus.respack = 1'b1;
      tick();
      if (!hold) bus.reqcyc = 1'b0;
      cyc = 0;
      while (cap_n < 8 && cyc < 60) begin
         if (bus.reqack) cap_acks++;
         if (bus.respcyc) begin
            if (cap_first < 0) cap_first = cyc;
            bus.reqcyc   = 1'b0;
            cap_d[cap_n] = bus.resp;
            cap_t[cap_n] = bus.resptag;
            cap_n++;
         end
         tick();
         cyc++;
      end
      bus.reqcyc = 1'b0;
      repeat (3) begin
         if (bus.reqack)  cap_acks++;
         if (bus.respcyc) cap_n++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (bus.reqack !== 1'b0)   $display("FAIL reset_reqack got %b exp 0", bus.reqack);   else passes++;
      checks++; if (bus.respcyc !== 1'b0)  $display("FAIL reset_respcyc got %b exp 0", bus.respcyc); else passes++;
      checks++; if (bus.resp !== 64'h0)    $display("FAIL reset_resp got %h exp 0", bus.resp);       else passes++;
      checks++; if (bus.resptag !== 13'h0) $display("FAIL reset_resptag got %h exp 0", bus.resptag); else passes++;
      reset = 1'b0;
      tick();
      checks++; if (bus.respcyc !== 1'b0)  $display("FAIL idle_respcyc got %b exp 0", bus.respcyc);  else passes++;
   endtask

   task automatic test_read();
      for (int i = 0; i < 8; i++) preload(AW'(8 + i), 64'h100 + 64'(i));
      collect_burst(64'h40, 13'h1005, 1'b0);
      checks++; if (cap_acks !== 1)        $display("FAIL read_acks got %0d exp 1", cap_acks);          else passes++;
      checks++; if (cap_first !== LATENCY) $display("FAIL read_latency got %0d exp %0d", cap_first, LATENCY); else passes++;
      checks++; if (cap_n !== 8)           $display("FAIL read_nbeats got %0d exp 8", cap_n);           else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++; if (cap_d[i] !== 64'h100 + 64'(i)) $display("FAIL read_data[%0d] got %h exp %h", i, cap_d[i], 64'h100 + 64'(i)); else passes++;
         checks++; if (cap_t[i] !== 13'h1005) $display("FAIL read_tag[%0d] got %h exp 1005", i, cap_t[i]); else passes++;
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      bus.respack = 1'b0;
      bus.reqcyc  = 1'b1;
      bus.req     = 64'h40;
      bus.reqtag  = 13'h1005;
      tick();
      bus.reqcyc = 1'b0;
      cyc = 0;
      while (!bus.respcyc && cyc < 20) begin tick(); cyc++; end
      checks++; if (bus.respcyc !== 1'b1) $display("FAIL bp_start respcyc got %b exp 1", bus.respcyc); else passes++;
      for (int b = 0; b < 8; b++) begin
         if (b == 2) begin
            for (int h = 0; h < 3; h++) begin
               bus.respack = 1'b0;
               checks++; if (bus.resp !== 64'h102 || bus.respcyc !== 1'b1) $display("FAIL bp_hold[%0d] got %h/%b exp 102/1", h, bus.resp, bus.respcyc); else passes++;
               tick();
            end
         end
         bus.respack = 1'b1;
         checks++; if (bus.resp !== 64'h100 + 64'(b) || bus.respcyc !== 1'b1) $display("FAIL bp_beat[%0d] got %h/%b exp %h/1", b, bus.resp, bus.respcyc, 64'h100 + 64'(b)); else passes++;
         tick();
      end
      checks++; if (bus.respcyc !== 1'b0) $display("FAIL bp_end respcyc got %b exp 0", bus.respcyc); else passes++;
   endtask

   task automatic test_write_read();
      int nacks = 0;
      int nresp = 0;
      bus.respack = 1'b1;
      bus.reqcyc  = 1'b1;
      bus.req     = 64'h80;
      bus.reqtag  = 13'h0007;
      tick();
      bus.reqcyc = 1'b0;
      checks++; if (bus.reqack !== 1'b1) $display("FAIL wr_reqack got %b exp 1", bus.reqack); else passes++;
      tick();
      for (int b = 0; b < 8; b++) begin
         bus.reqcyc = 1'b1;
         bus.req    = 64'hA0 + 64'(b);
         tick();
         if (bus.respcyc) nresp++;
         if (bus.reqack)  nacks++;
         bus.reqcyc = 1'b0;
         tick();
         if (bus.respcyc) nresp++;
         if (bus.reqack)  nacks++;
      end
      checks++; if (nresp !== 0) $display("FAIL wr_respcyc got %0d exp 0", nresp); else passes++;
      checks++; if (nacks !== 0) $display("FAIL wr_extra_acks got %0d exp 0", nacks); else passes++;
      collect_burst(64'h80, 13'h1002, 1'b0);
      checks++; if (cap_n !== 8) $display("FAIL rdw_nbeats got %0d exp 8", cap_n); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++; if (cap_d[i] !== 64'hA0 + 64'(i)) $display("FAIL rdw_data[%0d] got %h exp %h", i, cap_d[i], 64'hA0 + 64'(i)); else passes++;
      end
   endtask

   task automatic test_alias();
      collect_burst(64'h44, 13'h1001, 1'b0);
      checks++; if (cap_n !== 8) $display("FAIL unaligned_nbeats got %0d exp 8", cap_n); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++; if (cap_d[i] !== 64'h100 + 64'(i)) $display("FAIL unaligned_data[%0d] got %h exp %h", i, cap_d[i], 64'h100 + 64'(i)); else passes++;
      end
      collect_burst(64'h8040, 13'h1001, 1'b0);
      checks++; if (cap_n !== 8) $display("FAIL wrap_nbeats got %0d exp 8", cap_n); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++; if (cap_d[i] !== 64'h100 + 64'(i)) $display("FAIL wrap_data[%0d] got %h exp %h", i, cap_d[i], 64'h100 + 64'(i)); else passes++;
      end
   endtask

   task automatic test_reset_mid_resp();
      int cyc;
      bus.respack = 1'b1;
      bus.reqcyc  = 1'b1;
      bus.req     = 64'h40;
      bus.reqtag  = 13'h1009;
      tick();
      bus.reqcyc = 1'b0;
      cyc = 0;
      while (!bus.respcyc && cyc < 20) begin tick(); cyc++; end
      repeat (4) tick();
      checks++; if (bus.resp !== 64'h104) $display("FAIL mid_beat4 got %h exp 104", bus.resp); else passes++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (bus.respcyc !== 1'b0)  $display("FAIL mid_rst_respcyc got %b exp 0", bus.respcyc); else passes++;
      checks++; if (bus.resp !== 64'h0)    $display("FAIL mid_rst_resp got %h exp 0", bus.resp);       else passes++;
      checks++; if (bus.resptag !== 13'h0) $display("FAIL mid_rst_resptag got %h exp 0", bus.resptag); else passes++;
      checks++; if (bus.reqack !== 1'b0)   $display("FAIL mid_rst_reqack got %b exp 0", bus.reqack);   else passes++;
      tick();
      checks++; if (bus.respcyc !== 1'b0)  $display("FAIL mid_rst_idle got %b exp 0", bus.respcyc);    else passes++;
      collect_burst(64'h40, 13'h1005, 1'b0);
      checks++; if (cap_n !== 8) $display("FAIL post_rst_nbeats got %0d exp 8", cap_n); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++; if (cap_d[i] !== 64'h100 + 64'(i)) $display("FAIL post_rst_data[%0d] got %h exp %h", i, cap_d[i], 64'h100 + 64'(i)); else passes++;
      end
   endtask

   task automatic test_held_header();
      collect_burst(64'h40, 13'h1003, 1'b1);
      checks++; if (cap_acks !== 1) $display("FAIL held_acks got %0d exp 1", cap_acks); else passes++;
      checks++; if (cap_n !== 8)    $display("FAIL held_nbeats got %0d exp 8", cap_n);  else passes++;
      checks++; if (cap_first !== LATENCY) $display("FAIL held_latency got %0d exp %0d", cap_first, LATENCY); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++; if (cap_d[i] !== 64'h100 + 64'(i)) $display("FAIL held_data[%0d] got %h exp %h", i, cap_d[i], 64'h100 + 64'(i)); else passes++;
         checks++; if (cap_t[i] !== 13'h1003) $display("FAIL held_tag[%0d] got %h exp 1003", i, cap_t[i]); else passes++;
      end
   endtask

   initial begin
      bus.reqcyc  = 1'b0;
      bus.req     = '0;
      bus.reqtag  = '0;
      bus.respack = 1'b0;
      test_reset();
      test_read();
      test_backpressure();
      test_write_read();
      test_alias();
      test_reset_mid_resp();
      test_held_header();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sysbus_responder.md
# sysbus_responder

Memory-side responder for the Sysbus that the core's cache drives as initiator. It accepts one request at a time (a read header or a write header plus 8 data beats) and serves 64-byte lines from an internal word-addressed memory. Reads are answered with 8-beat bursts after a fixed latency. It serves as the memory model behind `top` in simulation and as the reference for the bus timing the cache must meet.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, data width of every bus beat
- BUS_TAG_WIDTH, 13, tag width; bit 12 is R/W (1 = read, 0 = write)
- MEM_WORDS, 4096, backing store depth in 64-bit words; multiple of 8
- LATENCY, 4, cycles from the reqack cycle to the first response beat; at least 1

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- bus_reqcyc  in  1  request/beat valid from initiator
- bus_req  in  BUS_DATA_WIDTH  byte address (header) or write data (beats)
- bus_reqtag  in  BUS_TAG_WIDTH  request tag; sampled with header only
- bus_reqack  out  1  header accepted, one-cycle pulse
- bus_respcyc  out  1  response beat valid
- bus_resp  out  BUS_DATA_WIDTH  response data
- bus_resptag  out  BUS_TAG_WIDTH  latched header tag
- bus_respack  in  1  initiator consumed current beat
- init_we  in  1  backdoor write strobe for bench preload
- init_addr  in  $clog2(MEM_WORDS)  backdoor word index
- init_data  in  64  backdoor data

## Operation
- States: IDLE, ACK, WDATA, WAIT, RESP.
- IDLE: when bus_reqcyc=1, latch tag and base = (bus_req[63:6]*8) mod MEM_WORDS, then go to ACK.
- ACK: bus_reqack=1 for exactly this cycle, and bus_reqcyc is ignored. Next state is WAIT if tag[12]=1, otherwise WDATA. Clear the beat counter; load the latency counter with LATENCY-1.
- WDATA: each cycle with bus_reqcyc=1 writes bus_req to mem[base+beat] and increments beat. After beat 7 is accepted, go to IDLE. Writes produce no response and no further acks.
- WAIT: decrement the latency counter; at 0 go to RESP.
- RESP: bus_respcyc=1, bus_resp=mem[base+beat], bus_resptag=latched tag, all held stable until bus_respack=1. On ack, beat increments and the next beat is presented the next cycle. After beat 7 is acked, go to IDLE.
- Bursts always start at the line-base word; there is no critical-word-first.
- Address arithmetic: word index = base+beat, 3-bit beat offset, wraps mod MEM_WORDS. Out-of-range addresses alias and never error.
- Backdoor writes: init_we writes mem[init_addr] in any state. If a bus write beat targets the same word in the same cycle, the bus beat wins.
- Memory contents are not cleared by reset.

## Timing
- Reset values: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, state IDLE, counters 0.
- Reset asserted mid-transaction aborts it the next edge. Write beats already accepted remain in memory; the remainder of the burst is dropped.
- Read timing with the header sampled at edge N:
  - bus_reqack high in cycle N+1.
  - First bus_respcyc in cycle N+1+LATENCY.
  - With bus_respack held high, the last beat is in cycle N+LATENCY+8.
  - IDLE in cycle N+LATENCY+9, where a new header can be sampled.
- Write timing: header at N, reqack at N+1, data beats sampled from N+2 whenever bus_reqcyc=1. Gaps are allowed. Back to IDLE the cycle after beat 7.
- A read issued right after a write completes returns the new data.
- bus_respack while bus_respcyc=0 is ignored.
- bus_reqcyc during WAIT or RESP is ignored; only one outstanding request.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Preload mem[8..15] = 0x100..0x107, read header addr 0x40, tag 0x1005, respack tied high. Expect: reqack at N+1; beats 0x100..0x107 in cycles N+5..N+12; resptag=0x1005 on every beat.
- Same read with respack low for 3 cycles on beat 2. Expect: beat 2 = 0x102 held 4 cycles, then 0x103 follows; still 8 beats total.
- Write header addr 0x80, tag 0x0007, data 0xA0..0xA7 with one-cycle gaps, then read 0x80. Expect: no respcyc for the write; read returns 0xA0..0xA7.
- Read addr 0x44 (unaligned) and read addr 0x40*MEM_WORDS/8 + 0x40. Expect: both return the line starting at word 8 (alignment and wrap).
- Reset pulsed in RESP after beat 3. Expect: all outputs 0 next cycle, state IDLE, preloaded memory intact; a new read returns the correct full burst.
- Header held high through ACK and WAIT. Expect: exactly one reqack pulse and exactly one 8-beat burst.
